// File: rtl/dmem_arbiter_if.sv
// +----------------------------------------------------------------------+
// | dmem_arbiter_if                                                      |
// | CPU, auxiliary and shared-memory signal bundle for dmem_arbiter.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface dmem_arbiter_if #(
  parameter int DATA_W = 32
) ();
  logic              cpu_req;
  logic              cpu_we;
  logic              cpu_byte;
  logic [DATA_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              aux_req;
  logic              aux_we;
  logic              aux_byte;
  logic [DATA_W-1:0] aux_addr;
  logic [DATA_W-1:0] aux_wdata;
  logic [DATA_W-1:0] aux_rdata;
  logic              aux_ack;

  logic              mem_we;
  logic              mem_byte;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  aux_req, aux_we, aux_byte, aux_addr, aux_wdata,
    output aux_rdata, aux_ack,
    output mem_we, mem_byte, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output aux_req, aux_we, aux_byte, aux_addr, aux_wdata,
    input  aux_rdata, aux_ack,
    input  mem_we, mem_byte, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// +----------------------------------------------------------------------+
// | dmem_arbiter                                                         |
// | Two-port (CPU / aux) arbiter onto one synchronous data memory.       |
// | Optional starvation guard for aux: define DMEM_ARB_STARVE_EN.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module dmem_arbiter #(
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  wire             clk,
  input  wire             reset,
  dmem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1,
    AUX_RD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              aux_ack_q, aux_ack_d;
  logic [DATA_W-1:0] aux_rdata_q, aux_rdata_d;

  logic aux_pending;
  logic aux_first;
  logic idle_ok;
  logic grant_cpu;
  logic grant_aux;

  // aux_req is still high during its own ack cycle; that access is already done
  assign aux_pending = bus.aux_req & ~aux_ack_q;
  assign idle_ok     = (state_q == IDLE) & ~reset;
  assign grant_aux   = idle_ok & aux_pending & (aux_first | ~bus.cpu_req);
  assign grant_cpu   = idle_ok & bus.cpu_req & ~grant_aux;

`ifdef DMEM_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_q, starve_d;

  assign aux_first = (starve_q >= CNT_W'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (!aux_pending || grant_aux) begin
      starve_d = '0;
    end else if (grant_cpu && (starve_q < CNT_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign aux_first = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    aux_ack_d     = 1'b0;
    aux_rdata_d   = aux_rdata_q;
    bus.mem_we    = 1'b0;
    bus.mem_byte  = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.cpu_rdata = '0;
    bus.cpu_stall = bus.cpu_req;

    case (state_q)
      IDLE: begin
        if (grant_cpu) begin
          bus.mem_we    = bus.cpu_we;
          bus.mem_byte  = bus.cpu_byte;
          bus.mem_addr  = bus.cpu_addr;
          bus.mem_wdata = bus.cpu_wdata;
          if (bus.cpu_we) begin
            bus.cpu_stall = 1'b0;
          end else begin
            state_d = CPU_RD;
          end
        end else if (grant_aux) begin
          bus.mem_we    = bus.aux_we;
          bus.mem_byte  = bus.aux_byte;
          bus.mem_addr  = bus.aux_addr;
          bus.mem_wdata = bus.aux_wdata;
          if (bus.aux_we) begin
            aux_ack_d = 1'b1;
          end else begin
            state_d = AUX_RD;
          end
        end
      end
      CPU_RD: begin
        bus.cpu_rdata = bus.mem_rdata;
        bus.cpu_stall = 1'b0;
        state_d       = IDLE;
      end
      AUX_RD: begin
        aux_rdata_d = bus.mem_rdata;
        aux_ack_d   = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      aux_ack_q   <= 1'b0;
      aux_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      aux_ack_q   <= aux_ack_d;
      aux_rdata_q <= aux_rdata_d;
    end
  end

  assign bus.aux_ack   = aux_ack_q;
  assign bus.aux_rdata = aux_rdata_q;

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_W, 32, data/address width; STARVE_LIMIT, 4, consecutive CPU grants tolerated while aux waits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 cpu_req  in  1  CPU data access request, held until completion.
REQ-005 cpu_we, cpu_byte  in  1 each  CPU write enable; byte-access mode.
REQ-006 cpu_addr, cpu_wdata  in  DATA_W each  CPU address; CPU write data.
REQ-007 cpu_rdata  out  DATA_W  CPU read data, valid in the completion cycle.
REQ-008 cpu_stall  out  1  high while cpu_req is pending and not completing this cycle.
REQ-009 aux_req, aux_we, aux_byte  in  1 each  auxiliary port request, write enable, byte mode.
REQ-010 aux_addr, aux_wdata  in  DATA_W each  auxiliary address; auxiliary write data.
REQ-011 aux_rdata  out  DATA_W  auxiliary read data, registered, valid when aux_ack=1.
REQ-012 aux_ack  out  1  one-cycle completion pulse for the aux access.
REQ-013 mem_we, mem_byte  out  1 each  shared memory write enable; byte mode.
REQ-014 mem_addr, mem_wdata  out  DATA_W each  shared memory address; write data.
REQ-015 mem_rdata  in  DATA_W  memory read data, one-cycle synchronous latency after address issue.

Function
REQ-016 FSM states SHALL be IDLE, CPU_RD, AUX_RD.
REQ-017 IDLE with no request: mem_we=0, mem_addr=0, state holds.
REQ-018 IDLE grant: CPU wins when both request, unless the starvation rule (REQ-024) forces aux.
REQ-019 Granted write: mem_we=1 with the winner's addr/wdata/byte in the grant cycle; completes that cycle (cpu_stall=0, or aux_ack=1 next cycle); state stays IDLE.
REQ-020 Granted read: address driven in the grant cycle with mem_we=0; next state CPU_RD or AUX_RD.
REQ-021 CPU_RD: cpu_rdata=mem_rdata combinationally; cpu_stall=0; next state IDLE; no new issue in this cycle.
REQ-022 AUX_RD: mem_rdata registered into aux_rdata; aux_ack=1 the following cycle; next state IDLE.
REQ-023 Latency: write 1 cycle; read 2 cycles; a read-read pair from one port SHALL take 4 cycles.
REQ-024 Starvation counter increments on each CPU grant while aux_req=1; it clears on any aux grant or when aux_req=0. On reaching STARVE_LIMIT, the next IDLE grant SHALL go to aux.
REQ-025 Aux SHALL hold aux_req and its fields stable until aux_ack; the block samples them only at grant.
REQ-026 cpu_stall = cpu_req AND NOT (CPU write granted this cycle OR state=CPU_RD).
REQ-027 An aux write ack and a CPU grant in the same cycle SHALL both be honoured.

Reset
REQ-028 Reset SHALL force state IDLE, counter 0, aux_ack=0, aux_rdata=0, mem_we=0.
REQ-029 Reset mid-read SHALL abandon the access: no ack, no rdata update, no memory write.

Configuration
REQ-030 Macro DMEM_ARB_STARVE_EN: when defined, REQ-024 is active; when undefined, fixed CPU priority applies, the counter is not built, and aux may starve indefinitely.

Verification
REQ-031 CPU write addr=0x100, data=0xDEADBEEF, aux idle -> mem_we=1 in the same cycle, cpu_stall=0.
REQ-032 CPU read addr=0x200, mem returns 0x12345678 -> cpu_stall=1 in cycle 0, cpu_rdata=0x12345678 with cpu_stall=0 in cycle 1.
REQ-033 Simultaneous CPU read and aux write -> CPU granted first; aux write issued in cycle 2; aux_ack in cycle 3.
REQ-034 STARVE_EN defined, CPU writes every cycle, aux_req held -> aux granted after 4 CPU grants, cpu_stall=1 that cycle.
REQ-035 Aux read of 0x300 (mem 0xCAFEF00D) -> aux_ack=1 with aux_rdata=0xCAFEF00D exactly 2 cycles after grant.
REQ-036 reset asserted in CPU_RD/AUX_RD -> state IDLE next cycle; no aux_ack; no mem_we.
